// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked CR16 ALU with a persistent status register
// and an iterative shift-add multiplier.
//
// Ports:
//   I_CLK      clock, all state updates on the rising edge
//   I_NRESET   asynchronous active-low reset
//   I_VALID    operation request; accepted when O_READY is high
//   O_READY    block can accept a request this cycle (low while multiplying)
//   I_OPCODE   operation select (0..15)
//   I_A, I_B   operands
//   O_VALID    one-cycle pulse when O_C / O_STATUS have been updated
//   O_C        registered result, held between results
//   O_STATUS   registered flags {N, Z, F, L, C}
module alu_seq #(
  parameter int WIDTH    = 16,
  parameter int MUL_STEP = 1
) (
  input  logic             I_CLK,
  input  logic             I_NRESET,
  input  logic             I_VALID,
  output logic             O_READY,
  input  logic [3:0]       I_OPCODE,
  input  logic [WIDTH-1:0] I_A,
  input  logic [WIDTH-1:0] I_B,
  output logic             O_VALID,
  output logic [WIDTH-1:0] O_C,
  output logic [4:0]       O_STATUS
);

  localparam int          STEPS  = WIDTH / MUL_STEP;
  localparam int          CW     = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int          SW     = $clog2(WIDTH);
  localparam int          M      = WIDTH - 1;
  localparam int unsigned STEP_U = MUL_STEP;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  // Flag bit positions inside O_STATUS
  localparam int F_C = 0;
  localparam int F_L = 1;
  localparam int F_F = 2;
  localparam int F_Z = 3;
  localparam int F_N = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADDU  = 4'd1,
    OP_ADDC  = 4'd2,
    OP_ADDCU = 4'd3,
    OP_SUB   = 4'd4,
    OP_SUBU  = 4'd5,
    OP_MUL   = 4'd6,
    OP_AND   = 4'd7,
    OP_OR    = 4'd8,
    OP_XOR   = 4'd9,
    OP_NOT   = 4'd10,
    OP_LSH   = 4'd11,
    OP_RSH   = 4'd12,
    OP_ALSH  = 4'd13,
    OP_ARSH  = 4'd14,
    OP_CMP   = 4'd15
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  // Registered state and outputs
  state_e           r_state;
  logic             r_ready;
  logic             r_valid;
  logic [WIDTH-1:0] r_c;
  logic [4:0]       r_status;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_prod;
  logic [CW-1:0]    r_cnt;

  // Combinational single-cycle datapath
  logic             w_accept;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_lt_u;
  logic             w_lt_s;
  logic             w_big;
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_asr;
  logic [WIDTH-1:0] w_res;
  logic [4:0]       w_flags;
  logic             w_wr_c;
  logic [WIDTH-1:0] w_step;

  assign O_READY  = r_ready;
  assign O_VALID  = r_valid;
  assign O_C      = r_c;
  assign O_STATUS = r_status;

  assign w_accept = I_VALID & r_ready;

  always_comb begin
    // Only the carry-consuming adds see the stored carry
    w_cin  = ((I_OPCODE == OP_ADDC) || (I_OPCODE == OP_ADDCU)) ? r_status[F_C] : 1'b0;
    w_sum  = {1'b0, I_A} + {1'b0, I_B} + {{WIDTH{1'b0}}, w_cin};
    w_diff = {1'b0, I_B} - {1'b0, I_A};
    w_lt_u = I_B < I_A;
    w_lt_s = $signed(I_B) < $signed(I_A);
    // Any bit above the shift-amount field means the shift is out of range
    w_big  = |I_B[WIDTH-1:SW];
    w_sh   = I_B[SW-1:0];
    // Kept as its own signal so the arithmetic shift is not turned unsigned
    // by mixing with unsigned operands in a conditional expression
    w_asr  = $signed(I_A) >>> w_sh;

    w_res   = r_c;
    w_flags = '0;
    w_wr_c  = 1'b1;

    case (I_OPCODE)
      OP_ADD, OP_ADDC: begin
        w_res        = w_sum[M:0];
        w_flags[F_F] = (I_A[M] == I_B[M]) && (w_sum[M] != I_A[M]);
        w_flags[F_N] = w_sum[M];
      end
      OP_ADDU, OP_ADDCU: begin
        w_res        = w_sum[M:0];
        w_flags[F_C] = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res        = w_diff[M:0];
        w_flags[F_F] = (I_B[M] != I_A[M]) && (w_diff[M] != I_B[M]);
        w_flags[F_N] = w_lt_s;
      end
      OP_SUBU: begin
        w_res        = w_diff[M:0];
        w_flags[F_C] = w_diff[WIDTH];
        w_flags[F_L] = w_lt_u;
      end
      OP_MUL: begin
        // Result comes from the iterative multiplier, not from here
        w_wr_c = 1'b0;
      end
      OP_AND:           w_res = I_A & I_B;
      OP_OR:            w_res = I_A | I_B;
      OP_XOR:           w_res = I_A ^ I_B;
      OP_NOT:           w_res = ~I_A;
      OP_LSH, OP_ALSH:  w_res = w_big ? '0 : (I_A << w_sh);
      OP_RSH:           w_res = w_big ? '0 : (I_A >> w_sh);
      OP_ARSH:          w_res = w_big ? {WIDTH{I_A[M]}} : w_asr;
      OP_CMP: begin
        w_wr_c       = 1'b0;
        w_flags[F_L] = w_lt_u;
        w_flags[F_N] = w_lt_s;
      end
      default: ;
    endcase

    if (I_OPCODE == OP_CMP) begin
      w_flags[F_Z] = (I_A == I_B);
    end else begin
      w_flags[F_Z] = (w_res == '0);
    end
  end

  // One multiplier iteration: add the partial products for the next
  // MUL_STEP multiplier bits to the running product
  always_comb begin
    w_step = r_prod;
    for (int unsigned j = 0; j < STEP_U; j++) begin
      if (r_mplier[j]) begin
        w_step = w_step + (r_mcand << j);
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_c      <= '0;
      r_status <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (I_OPCODE == OP_MUL) begin
              r_state  <= S_MUL;
              r_ready  <= 1'b0;
              r_mcand  <= I_A;
              r_mplier <= I_B;
              r_prod   <= '0;
              r_cnt    <= '0;
            end else begin
              r_valid  <= 1'b1;
              r_status <= w_flags;
              if (w_wr_c) begin
                r_c <= w_res;
              end
            end
          end
        end
        S_MUL: begin
          r_prod   <= w_step;
          r_mcand  <= r_mcand << MUL_STEP;
          r_mplier <= r_mplier >> MUL_STEP;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b1;
            r_c      <= w_step;
            r_status <= {1'b0, (w_step == '0), 3'b000};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         vld, rdy, ovld;
  logic [3:0]   op;
  logic [W-1:0] a, b, c;
  logic [4:0]   st;

  logic         vld4, rdy4, ovld4;
  logic [3:0]   op4;
  logic [W-1:0] a4, b4, c4;
  logic [4:0]   st4;

  alu_seq #(.WIDTH(W), .MUL_STEP(1)) dut (
    .I_CLK(clk), .I_NRESET(rst_n), .I_VALID(vld), .O_READY(rdy),
    .I_OPCODE(op), .I_A(a), .I_B(b), .O_VALID(ovld), .O_C(c), .O_STATUS(st)
  );

  alu_seq #(.WIDTH(W), .MUL_STEP(4)) dut4 (
    .I_CLK(clk), .I_NRESET(rst_n), .I_VALID(vld4), .O_READY(rdy4),
    .I_OPCODE(op4), .I_A(a4), .I_B(b4), .O_VALID(ovld4), .O_C(c4), .O_STATUS(st4)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [4:0]   st;
  } vec_t;

  localparam int NV = 26;
  vec_t vt[NV];

  // Issue one MUL on the selected instance, optionally poking ignored ADD
  // requests during the busy window, and check latency and result.
  task automatic do_mul(input int sel, input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input int exp_lat, input logic [W-1:0] ec, input logic [4:0] es,
                        input bit inject);
    int  lat;
    int  rdy_bad;
    bit  seen;
    logic [W-1:0] held;
    @(negedge clk);
    if (sel == 0) begin op = 4'd6; a = ma; b = mb; vld = 1'b1; end
    else          begin op4 = 4'd6; a4 = ma; b4 = mb; vld4 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0; vld4 = 1'b0;
    lat = 0; rdy_bad = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if ((sel == 0) ? ovld : ovld4) begin
        seen = 1'b1;
      end else begin
        if ((sel == 0) ? rdy : rdy4) rdy_bad++;
        lat++;
        if (inject && sel == 0 && k < 12 && (k % 2) == 1) begin
          op = 4'd0; a = 16'h0001; b = 16'h0001; vld = 1'b1;
        end else begin
          vld = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
    vld = 1'b0;
    chk($sformatf("mul%0d seen", sel), 32'(seen), 32'd1);
    chk($sformatf("mul%0d latency", sel), 32'(lat), 32'(exp_lat));
    chk($sformatf("mul%0d ready_low", sel), 32'(rdy_bad), 32'd0);
    chk($sformatf("mul%0d C", sel), 32'((sel == 0) ? c : c4), 32'(ec));
    chk($sformatf("mul%0d status", sel), 32'((sel == 0) ? st : st4), 32'(es));
    chk($sformatf("mul%0d ready_back", sel), 32'((sel == 0) ? rdy : rdy4), 32'd1);
    held = (sel == 0) ? c : c4;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("mul%0d pulse_end", sel), 32'((sel == 0) ? ovld : ovld4), 32'd0);
    chk($sformatf("mul%0d C_held", sel), 32'((sel == 0) ? c : c4), 32'(held));
  endtask

  initial begin
    int cnt;

    vt[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 5'b10100};
    vt[1]  = '{4'd1,  16'hFFFF, 16'h0001, 16'h0000, 5'b01001};
    vt[2]  = '{4'd3,  16'h0000, 16'h0000, 16'h0001, 5'b00000};
    vt[3]  = '{4'd2,  16'h0001, 16'h0002, 16'h0003, 5'b00000};
    vt[4]  = '{4'd1,  16'h8000, 16'h8000, 16'h0000, 5'b01001};
    vt[5]  = '{4'd2,  16'h7FFF, 16'h0000, 16'h8000, 5'b10100};
    vt[6]  = '{4'd4,  16'h0001, 16'h0000, 16'hFFFF, 5'b10000};
    vt[7]  = '{4'd4,  16'h0001, 16'h8000, 16'h7FFF, 5'b10100};
    vt[8]  = '{4'd5,  16'h0005, 16'h0003, 16'hFFFE, 5'b00011};
    vt[9]  = '{4'd5,  16'h0003, 16'h0003, 16'h0000, 5'b01000};
    vt[10] = '{4'd7,  16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000};
    vt[11] = '{4'd8,  16'h0F00, 16'h00F0, 16'h0FF0, 5'b00000};
    vt[12] = '{4'd9,  16'hAAAA, 16'hAAAA, 16'h0000, 5'b01000};
    vt[13] = '{4'd10, 16'hFFFF, 16'h1234, 16'h0000, 5'b01000};
    vt[14] = '{4'd11, 16'h0001, 16'd15,   16'h8000, 5'b00000};
    vt[15] = '{4'd12, 16'h8000, 16'd16,   16'h0000, 5'b01000};
    vt[16] = '{4'd14, 16'h8000, 16'd20,   16'hFFFF, 5'b00000};
    vt[17] = '{4'd13, 16'h00FF, 16'd4,    16'h0FF0, 5'b00000};
    vt[18] = '{4'd14, 16'h8000, 16'd3,    16'hF000, 5'b00000};
    vt[19] = '{4'd12, 16'h8000, 16'd3,    16'h1000, 5'b00000};
    vt[20] = '{4'd15, 16'h0005, 16'hFFFF, 16'h1000, 5'b10000};
    vt[21] = '{4'd15, 16'h1234, 16'h1234, 16'h1000, 5'b01000};
    vt[22] = '{4'd11, 16'h0001, 16'h0100, 16'h0000, 5'b01000};
    vt[23] = '{4'd14, 16'h4000, 16'hFFFF, 16'h0000, 5'b01000};
    vt[24] = '{4'd15, 16'hFFFF, 16'h0001, 16'h0000, 5'b00010};
    vt[25] = '{4'd3,  16'h0000, 16'h0000, 16'h0000, 5'b01000};

    rst_n = 1'b0;
    vld = 1'b0; op = '0; a = '0; b = '0;
    vld4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(rdy), 32'd1);
    chk("reset valid", 32'(ovld), 32'd0);
    chk("reset C", 32'(c), 32'd0);
    chk("reset status", 32'(st), 32'd0);
    rst_n = 1'b1;

    // Back-to-back table: one request per cycle, checked the cycle after accept
    @(negedge clk);
    op = vt[0].op; a = vt[0].a; b = vt[0].b; vld = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), 32'(ovld), 32'd1);
      chk($sformatf("vec%0d C", i), 32'(c), 32'(vt[i].c));
      chk($sformatf("vec%0d status", i), 32'(st), 32'(vt[i].st));
      if (i + 1 < NV) begin
        op = vt[i+1].op; a = vt[i+1].a; b = vt[i+1].b;
      end else begin
        vld = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("table pulse_end", 32'(ovld), 32'd0);

    // Multiplier, default build, with ignored requests during the busy window
    do_mul(0, 16'hFFFE, 16'h0003, 16, 16'hFFFA, 5'b00000, 1'b1);
    do_mul(0, 16'h00FF, 16'h0101, 16, 16'hFFFF, 5'b00000, 1'b0);

    // Four-bits-per-cycle build
    do_mul(1, 16'h0100, 16'h0100, 4, 16'h0000, 5'b01000, 1'b0);
    do_mul(1, 16'h0123, 16'h0045, 4, 16'h4E6F, 5'b00000, 1'b0);

    // Reset in the 8th multiplier cycle aborts the operation
    @(negedge clk);
    op = 4'd6; a = 16'h0003; b = 16'h0005; vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort busy", 32'(rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort C", 32'(c), 32'd0);
    chk("abort status", 32'(st), 32'd0);
    chk("abort ready", 32'(rdy), 32'd1);
    chk("abort valid", 32'(ovld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (ovld) cnt++;
    end
    chk("abort no_pulse", 32'(cnt), 32'd0);

    // Stored carry was cleared by reset
    op = 4'd3; a = 16'h0000; b = 16'h0000; vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    chk("post_reset valid", 32'(ovld), 32'd1);
    chk("post_reset C", 32'(c), 32'd0);
    chk("post_reset status", 32'(st), 32'(5'b01000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
